// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer with conditional/relative branches, halt and saturating retire count.
// Define PC_SEQ_LINK_EN to add the single-entry link register (LinkEn/Return/LinkAddr).
module pc_sequencer #(
  parameter int PC_W = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0
)(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             HaltIn,
  input  logic             BranchEn,
  input  logic             BranchCond,
  input  logic             BranchRel,
  input  logic [PC_W-1:0]  Target,
  input  logic [OFF_W-1:0] Offset,
  input  logic             FlagIn,
`ifdef PC_SEQ_LINK_EN
  input  logic             LinkEn,
  input  logic             Return,
  output logic [PC_W-1:0]  LinkAddr,
`endif
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic             BranchTaken,
  output logic [CNT_W-1:0] RetiredCnt
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, stateNext;
  logic [PC_W-1:0] pcNext, pcInc, pcBranch;
  logic [CNT_W-1:0] cntNext;
  logic retire, doReturn;
  assign pcInc = PC + PC_W'(1);
  assign pcBranch = BranchRel ? PC + PC_W'($signed(Offset)) : Target;
  assign Running = state == RUN;
  assign Done = state == HALTED;
`ifdef PC_SEQ_LINK_EN
  logic [PC_W-1:0] linkNext;
  assign doReturn = Return;
`else
  assign doReturn = 1'b0;
`endif
  always_comb begin
    stateNext = state;
    pcNext = PC;
    cntNext = RetiredCnt;
    retire = 1'b0;
    BranchTaken = Running && !Stall && !HaltIn && BranchEn && (!BranchCond || FlagIn);
`ifdef PC_SEQ_LINK_EN
    linkNext = (BranchTaken && LinkEn && !Return) ? pcInc : LinkAddr;
`endif
    if (!Running) begin
      if (Start) begin
        stateNext = RUN;
        pcNext = StartAddr;
        cntNext = '0;
      end
    end else if (HaltIn) begin
      stateNext = HALTED;
      retire = 1'b1;
    end else if (!Stall) begin
      retire = 1'b1;
      pcNext = doReturn ? PC_W'(0) : BranchTaken ? pcBranch : pcInc;
`ifdef PC_SEQ_LINK_EN
      pcNext = doReturn ? LinkAddr : pcNext;
`endif
    end
    if (retire && !(&RetiredCnt)) cntNext = RetiredCnt + CNT_W'(1);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PC <= START_ADDR;
      RetiredCnt <= '0;
`ifdef PC_SEQ_LINK_EN
      LinkAddr <= '0;
`endif
    end else begin
      state <= stateNext;
      PC <= pcNext;
      RetiredCnt <= cntNext;
`ifdef PC_SEQ_LINK_EN
      LinkAddr <= linkNext;
`endif
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; a reference model pushes expected state per cycle.
module tb_pc_sequencer;
  localparam int PC_W = 10;
  localparam int OFF_W = 8;
  localparam int CNT_W = 4;
  logic Clk = 1'b0;
  logic Reset, Start, Stall, HaltIn, BranchEn, BranchCond, BranchRel, FlagIn;
  logic [PC_W-1:0] StartAddr, Target, PC;
  logic [OFF_W-1:0] Offset;
  logic Running, Done, BranchTaken;
  logic [CNT_W-1:0] RetiredCnt;
  logic linkEnV = 1'b0, returnV = 1'b0;
  logic [PC_W-1:0] mLink = '0;
`ifdef PC_SEQ_LINK_EN
  logic [PC_W-1:0] LinkAddr;
`endif
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic run;
    logic done;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t expQ[$];
  int checks = 0, errors = 0;
  int mSt = 0;
  logic [PC_W-1:0] mPc = '0;
  logic [CNT_W-1:0] mCnt = '0;
  pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W), .START_ADDR('0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Stall(Stall),
    .HaltIn(HaltIn), .BranchEn(BranchEn), .BranchCond(BranchCond), .BranchRel(BranchRel),
    .Target(Target), .Offset(Offset), .FlagIn(FlagIn),
`ifdef PC_SEQ_LINK_EN
    .LinkEn(linkEnV), .Return(returnV), .LinkAddr(LinkAddr),
`endif
    .PC(PC), .Running(Running), .Done(Done), .BranchTaken(BranchTaken), .RetiredCnt(RetiredCnt)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    exp_t e;
    logic bt, rt;
    #1;
    bt = mSt == 1 && !Stall && !HaltIn && BranchEn && (!BranchCond || FlagIn);
    check("BranchTaken", {31'd0, BranchTaken}, {31'd0, bt});
    rt = 1'b0;
    if (Reset) begin
      mSt = 0; mPc = '0; mCnt = '0; mLink = '0;
    end else if (mSt != 1) begin
      if (Start) begin mSt = 1; mPc = StartAddr; mCnt = '0; end
    end else if (HaltIn) begin
      mSt = 2; rt = 1'b1;
    end else if (!Stall) begin
      rt = 1'b1;
      if (returnV) mPc = mLink;
      else if (bt) begin
        if (linkEnV) mLink = mPc + 10'd1;
        mPc = BranchRel ? mPc + {{(PC_W-OFF_W){Offset[OFF_W-1]}}, Offset} : Target;
      end else mPc = mPc + 10'd1;
    end
    if (rt && mCnt != {CNT_W{1'b1}}) mCnt = mCnt + 4'd1;
    e.pc = mPc; e.run = mSt == 1; e.done = mSt == 2; e.cnt = mCnt;
    expQ.push_back(e);
    @(posedge Clk);
    #1;
    if (expQ.size() == 0) check("queue", 0, 1);
    else begin
      e = expQ.pop_front();
      check("PC", 32'(PC), 32'(e.pc));
      check("Running", {31'd0, Running}, {31'd0, e.run});
      check("Done", {31'd0, Done}, {31'd0, e.done});
      check("RetiredCnt", 32'(RetiredCnt), 32'(e.cnt));
`ifdef PC_SEQ_LINK_EN
      check("LinkAddr", 32'(LinkAddr), 32'(mLink));
`endif
    end
  endtask
  task automatic branch(input logic cond, input logic rel, input logic [PC_W-1:0] tgt, input logic [OFF_W-1:0] off);
    BranchEn = 1'b1; BranchCond = cond; BranchRel = rel; Target = tgt; Offset = off;
  endtask
  initial begin
    {Start, Stall, HaltIn, BranchEn, BranchCond, BranchRel, FlagIn} = '0;
    StartAddr = '0; Target = '0; Offset = '0;
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    cycle();
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_run", {31'd0, Running}, 32'd0);
    Reset = 1'b0;
    cycle();
    Start = 1'b1; StartAddr = 10'h010;
    cycle();
    Start = 1'b0;
    check("start_pc", 32'(PC), 32'h010);
    for (int i = 0; i < 3; i++) cycle();
    check("inc_pc", 32'(PC), 32'h013);
    check("inc_cnt", 32'(RetiredCnt), 32'd3);
    branch(1'b0, 1'b0, 10'h020, 8'h00);
    cycle();
    branch(1'b1, 1'b1, 10'h000, 8'hFC);
    FlagIn = 1'b0;
    cycle();
    check("cond_nt_pc", 32'(PC), 32'h021);
    FlagIn = 1'b1;
    cycle();
    check("cond_t_pc", 32'(PC), 32'h01D);
    Offset = 8'h00;
    cycle();
    check("self_loop", 32'(PC), 32'h01D);
    branch(1'b0, 1'b0, 10'h3FF, 8'h00);
    cycle();
    BranchEn = 1'b0;
    cycle();
    check("wrap_up", 32'(PC), 32'h000);
    branch(1'b0, 1'b1, 10'h000, 8'hFF);
    cycle();
    check("wrap_down", 32'(PC), 32'h3FF);
    BranchEn = 1'b0;
    cycle();
    branch(1'b0, 1'b0, 10'h155, 8'h00);
    Stall = 1'b1;
    cycle();
    check("stall_pc", 32'(PC), 32'h000);
    Stall = 1'b0;
    cycle();
    check("post_stall", 32'(PC), 32'h155);
    branch(1'b0, 1'b0, 10'h040, 8'h00);
    cycle();
    HaltIn = 1'b1; Stall = 1'b1;
    cycle();
    check("halt_pc", 32'(PC), 32'h040);
    check("halt_done", {31'd0, Done}, 32'd1);
    check("halt_cnt", 32'(RetiredCnt), 32'd14);
    {HaltIn, Stall, BranchEn} = '0;
    cycle();
    Start = 1'b1; StartAddr = 10'h000;
    cycle();
    check("restart_cnt", 32'(RetiredCnt), 32'd0);
    StartAddr = 10'h200;
    cycle();
    check("start_ignored", 32'(PC), 32'h001);
    Start = 1'b0;
    for (int i = 0; i < 16; i++) cycle();
    check("sat_cnt", 32'(RetiredCnt), 32'hF);
    branch(1'b0, 1'b0, 10'h123, 8'h00);
    Reset = 1'b1;
    cycle();
    check("mid_rst_pc", 32'(PC), 32'h000);
    check("mid_rst_run", {31'd0, Running}, 32'd0);
    Reset = 1'b0; BranchEn = 1'b0;
    cycle();
`ifdef PC_SEQ_LINK_EN
    Start = 1'b1; StartAddr = 10'h050;
    cycle();
    Start = 1'b0;
    branch(1'b0, 1'b0, 10'h100, 8'h00);
    linkEnV = 1'b1;
    cycle();
    check("link_addr", 32'(LinkAddr), 32'h051);
    BranchEn = 1'b0; linkEnV = 1'b0;
    cycle();
    returnV = 1'b1;
    cycle();
    check("return_pc", 32'(PC), 32'h051);
    returnV = 1'b0;
    cycle();
`endif
    if (expQ.size() != 0) check("queue_drain", 32'(expQ.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
